wordred_iter: RTL
=================

Name: wordred_iter

Overview:
- Iterative, parametrised successor to the single-step word-level Montgomery reducer, for moduli q = qH*2^W + 1.
- Runs a per-transaction number of word-reduction steps (0..MAX_ITER) on one shared multiplier: T ≡ C * 2^(-W*n_iter) mod q.
- Valid/ready on both sides. Sits between the wide product stage and the modmul output stage.

Parameters:
- LOGC, 120, input operand width in bits; must be > W.
- LOGQH, 26, qH width in bits.
- W, 34, reduction word width (bits removed per step).
- MAX_ITER, 4, maximum steps per transaction; must be >= 1.
- STEP_LAT, 1, cycles per step: 1 = combinational multiply; 2 = product registered before summation.
- LOGX, max(LOGC, LOGQH+W+1), derived: internal accumulator and output width.
- LOGN, $clog2(MAX_ITER+1), derived: n_iter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept; high only in IDLE.
- qH  in  LOGQH  modulus high part; captured on accept.
- C  in  LOGC  operand; captured on accept.
- n_iter  in  LOGN  step count; captured on accept; values > MAX_ITER saturate to MAX_ITER.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  downstream accepts result.
- T  out  LOGX  result; held stable while out_valid=1.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, out_valid=0, T=0, step counter=0, all internal registers=0. in_ready=1 once rst_n deasserts. Any in-flight transaction is discarded.
- FSM:
  - IDLE: on in_valid&in_ready, capture qH, X=zero-extend(C), cnt=min(n_iter, MAX_ITER). Go to STEP if cnt>0, else DONE.
  - STEP: one reduction per STEP_LAT cycles. After the last step go to DONE (or FSUB when the optional feature is enabled).
  - DONE: out_valid=1, T=X. On out_ready, go to IDLE.
- Step arithmetic, all unsigned:
  - CL = X[W-1:0]; CLN = (-CL) mod 2^W; carry = (CL != 0).
  - X' = qH*CLN + (X >> W) + carry, stored in LOGX bits.
  - No overflow is possible because LOGX >= LOGQH+W+1. The bench asserts this.
- STEP_LAT=2: cycle A registers qH*CLN, X>>W and carry; cycle B sums them and writes X.
- Latency, accept to out_valid:
  - 1 + cnt*STEP_LAT cycles.
  - cnt=0 gives 1 cycle (pass-through, T=C).
  - Plus 1 cycle when the optional feature is enabled and cnt>0.
- Back-to-back operation: a new accept is possible in the cycle after the out handshake. No overlap; single transaction in flight.
- Input stability: C, qH and n_iter are sampled only at accept and may change afterwards.
- Output stall: DONE holds T and out_valid indefinitely while out_ready=0.
- in_valid while not in_ready: ignored, no capture.

Optional Feature:
- Macro: WORDRED_ITER_FINSUB_EN.
- Enabled:
  - Extra state FSUB after the last step: if X >= q (q = {qH, W'b0} + 1) then X = X - q; then go to DONE.
  - T < q whenever cnt > 0 and C < q*2^(W*cnt).
  - For cnt=0, FSUB is skipped and T=C.
- Disabled: no FSUB state; T is the raw last-step value, possibly >= q.

Test Plan:
- Override W=4, LOGQH=4, LOGC=16, qH=1 (q=17). C=5, n_iter=1 -> T=12 (12*16 mod 17 = 5), out_valid exactly 1+STEP_LAT cycles after accept.
- Same parameters, C=5, n_iter=2 -> T=5, latency 1+2*STEP_LAT; then C=0x0123, n_iter=0 -> T=0x0123 after 1 cycle.
- Same parameters, C=255, n_iter=1:
  - macro disabled -> T=17.
  - macro enabled -> T=0, one extra cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> T and out_valid stable, in_ready=0; a pulse on in_valid is ignored; after out_ready=1 the next accept works.
- rst_n low mid-STEP with MAX_ITER=4, n_iter=4 -> out_valid=0 and T=0 immediately (asynchronous); after release, in_ready=1 and a fresh C=5, n_iter=1 gives T=12.
- Default parameters, 10k random C, qH and n_iter per STEP_LAT in {1,2}:
  - T*2^(W*cnt) ≡ C mod q.
  - n_iter > MAX_ITER behaves as MAX_ITER.

Source files
------------

// File: rtl/wordred_iter.sv
// wordred_iter: iterative word-level Montgomery reducer for q = qH*2^W + 1.
// Each transaction runs min(n_iter, MAX_ITER) steps on one shared multiplier,
// producing T == C * 2^(-W*cnt) mod q (not fully reduced unless FSUB is built).
// Optional final conditional subtraction: define WORDRED_ITER_FINSUB_EN.
module wordred_iter #(
  parameter int unsigned LOGC     = 120,
  parameter int unsigned LOGQH    = 26,
  parameter int unsigned W        = 34,
  parameter int unsigned MAX_ITER = 4,
  parameter int unsigned STEP_LAT = 1,
  parameter int unsigned LOGX     = (LOGC > LOGQH + W + 1) ? LOGC : (LOGQH + W + 1),
  parameter int unsigned LOGN     = $clog2(MAX_ITER + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQH-1:0] qH,
  input  logic [LOGC-1:0] C,
  input  logic [LOGN-1:0] n_iter,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGX-1:0] T
);

  localparam int unsigned LOGP = LOGQH + W;
  localparam int unsigned LOGH = LOGX - W;

`ifdef WORDRED_ITER_FINSUB_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_DONE = 2'd2, S_FSUB = 2'd3} state_e;
  localparam state_e S_AFTER = S_FSUB;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_DONE = 2'd2} state_e;
  localparam state_e S_AFTER = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [LOGX-1:0]   x_q, x_d;
  logic [LOGQH-1:0]  qh_q, qh_d;
  logic [LOGN-1:0]   cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [W-1:0]      cl_c, cln_c;
  logic [LOGP-1:0]   prod_c;
  logic [LOGH-1:0]   hi_c;
  logic              carry_c;
  logic [LOGX-1:0]   sum_c;
  logic              step_wr_c;

  // One word-reduction step's operands taken from the current accumulator
  always_comb begin
    cl_c    = x_q[W-1:0];
    cln_c   = W'(0) - cl_c;
    carry_c = (cl_c != '0);
    prod_c  = LOGP'(qh_q) * LOGP'(cln_c);
    hi_c    = x_q[LOGX-1:W];
  end

  generate
    if (STEP_LAT == 2) begin : g_lat2
      logic            phase_q, phase_d;
      logic [LOGP-1:0] prod_q, prod_d;
      logic [LOGH-1:0] hi_q, hi_d;
      logic            carry_q, carry_d;

      // Phase A registers product/shift/carry, phase B sums them into X
      always_comb begin
        phase_d = 1'b0;
        prod_d  = prod_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        if (state_q == S_STEP) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            prod_d  = prod_c;
            hi_d    = hi_c;
            carry_d = carry_c;
          end
        end
      end

      // Pipeline registers between multiply and summation
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_q <= 1'b0;
          prod_q  <= '0;
          hi_q    <= '0;
          carry_q <= 1'b0;
        end else begin
          phase_q <= phase_d;
          prod_q  <= prod_d;
          hi_q    <= hi_d;
          carry_q <= carry_d;
        end
      end

      assign step_wr_c = phase_q;
      assign sum_c     = LOGX'(prod_q) + LOGX'(hi_q) + LOGX'(carry_q);
    end else begin : g_lat1
      assign step_wr_c = 1'b1;
      assign sum_c     = LOGX'(prod_c) + LOGX'(hi_c) + LOGX'(carry_c);
    end
  endgenerate

`ifdef WORDRED_ITER_FINSUB_EN
  logic [LOGX-1:0] q_c;
  assign q_c = LOGX'({qh_q, W'(0)}) + LOGX'(1);
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    qh_d    = qh_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          qh_d    = qH;
          x_d     = LOGX'(C);
          cnt_d   = (n_iter > LOGN'(MAX_ITER)) ? LOGN'(MAX_ITER) : n_iter;
          state_d = (cnt_d != '0) ? S_STEP : S_DONE;
        end
      end
      S_STEP: begin
        if (step_wr_c) begin
          x_d   = sum_c;
          cnt_d = cnt_q - LOGN'(1);
          if (cnt_q == LOGN'(1)) state_d = S_AFTER;
        end
      end
`ifdef WORDRED_ITER_FINSUB_EN
      S_FSUB: begin
        if (x_q >= q_c) x_d = x_q - q_c;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, accumulator and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      qh_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      qh_q        <= qh_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign T         = x_q;

endmodule
